ddr2_port_arbiter: RTL
======================

DDR2_PORT_ARBITER -- requirements
Module: ddr2_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 32, data width | ADDR_W, 30, byte address width | BE_W, 4, byte-enable width | MAX_PENDING, 16, outstanding-read tag depth (power of 2).
REQ-002 Ports (name, direction, width, meaning): clk in 1 DDR2 local-side clock; reset in 1 synchronous, active-high reset.
REQ-003 m0_address in ADDR_W, m0_byteenable in BE_W, m0_read in 1, m0_write in 1, m0_writedata in DATA_W: CPU bridge master command.
REQ-004 m0_waitrequest out 1, m0_readdata out DATA_W, m0_readdatavalid out 1: CPU bridge master response.
REQ-005 m1_* ports: identical set and widths for the acquisition DMA master.
REQ-006 ddr_address out ADDR_W, ddr_byteenable out BE_W, ddr_read out 1, ddr_write out 1, ddr_writedata out DATA_W: shared DDR2 port command.
REQ-007 ddr_waitrequest in 1, ddr_readdata in DATA_W, ddr_readdatavalid in 1: shared DDR2 port response; read data returns in issue order.
REQ-008 err_orphan out 1: sticky flag, readdatavalid received with no outstanding tag.

Function
REQ-009 FSM states IDLE, GRANT0, GRANT1; state is registered.
REQ-010 IDLE: no requests -> stay; otherwise go to GRANTx of the eligible winner, so first command reaches ddr_* one cycle after the request.
REQ-011 A read request is eligible only if tag count < MAX_PENDING; write requests are always eligible.
REQ-012 Both eligible: winner = master not served last (round-robin pointer, 0 after reset).
REQ-013 GRANTx: ddr_address/byteenable/read/write/writedata = mx_*; mx_waitrequest = ddr_waitrequest.
REQ-014 Non-granted master's waitrequest = 1 whenever it requests; a master with no request sees waitrequest = 1 in IDLE as well.
REQ-015 Acceptance = granted ddr_read|ddr_write high and ddr_waitrequest low; at acceptance the pointer moves to the other master.
REQ-016 On acceptance the FSM re-arbitrates using the next-cycle eligibility: next state = GRANTy of the new winner, or IDLE if none. Back-to-back commands are allowed; there is no idle bubble.
REQ-017 Grant is never revoked while ddr_waitrequest holds the command; command fields stay stable as the master's Avalon obligation.
REQ-018 Granted master drops its request without acceptance -> return to IDLE next cycle.
REQ-019 ddr_read and ddr_write are 0 in IDLE; address and data are don't-care but driven from m0.
REQ-020 Tag FIFO: push the granted master ID on read acceptance; pop on ddr_readdatavalid.
REQ-021 Simultaneous push and pop leaves the count unchanged; FIFO pointers wrap modulo MAX_PENDING.
REQ-022 Count width = log2(MAX_PENDING)+1.
REQ-023 mx_readdata = ddr_readdata (broadcast); mx_readdatavalid = ddr_readdatavalid & (head tag == x) & count != 0; zero added latency.
REQ-024 ddr_readdatavalid with count == 0: no pop, neither master gets valid, err_orphan <= 1.

Reset
REQ-025 reset sampled at clk rising edge; FSM -> IDLE, pointer -> 0, tag count and pointers -> 0, err_orphan -> 0.
REQ-026 Output values during and after reset: ddr_read = ddr_write = 0, mx_readdatavalid = 0, mx_waitrequest = 1.
REQ-027 Reset mid-transfer discards the held command and all pending tags; later stray readdatavalid sets err_orphan.

Configuration
REQ-028 Macro DDR2_ARB_FIXED_PRIORITY_EN defined: m1 always wins ties, and the pointer is ignored.
REQ-029 DDR2_ARB_FIXED_PRIORITY_EN undefined: round-robin per REQ-012.

Verification
REQ-030 m0 write only, ddr_waitrequest=0 -> ddr_write=1 one cycle after m0_write, m0_waitrequest=0 that cycle, then IDLE.
REQ-031 m0 and m1 continuous reads from reset (round-robin build) -> ddr_read sources alternate m0,m1,m0...; readdatavalid routed in matching order.
REQ-032 m1 read held with ddr_waitrequest=1 for 5 cycles while m0 requests -> GRANT1 held for 5 cycles, m0_waitrequest=1, then m0 granted after acceptance.
REQ-033 16 m0 reads accepted, no data returned -> 17th read not granted, m0_waitrequest=1; one readdatavalid -> read granted on the following arbitration.
REQ-034 ddr_readdatavalid pulse after reset with no reads -> err_orphan=1, both readdatavalid=0; reset -> err_orphan=0.
REQ-035 FIXED_PRIORITY build with continuous requests from both masters -> every grant goes to m1, and m0 is served only when m1 is idle.

Source files
------------

// File: rtl/ddr2_port_arbiter.sv
// Two-master Avalon arbiter onto one DDR2 local port, with an in-order read tag FIFO for response routing.
// Build option: DDR2_ARB_FIXED_PRIORITY_EN makes m1 win every tie; otherwise round-robin.
module ddr2_port_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 30,
  parameter int BE_W        = 4,
  parameter int MAX_PENDING = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ddr_address,
  output logic [BE_W-1:0]   ddr_byteenable,
  output logic              ddr_read,
  output logic              ddr_write,
  output logic [DATA_W-1:0] ddr_writedata,
  input  logic              ddr_waitrequest,
  input  logic [DATA_W-1:0] ddr_readdata,
  input  logic              ddr_readdatavalid,
  output logic              err_orphan
);
  localparam int PW = $clog2(MAX_PENDING);
  localparam int CW = $clog2(MAX_PENDING) + 1;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t                 state_q, state_d;
  logic                   rr_q, rr_d;
  logic [MAX_PENDING-1:0] tag_q;
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q;
  logic                   accept, push, pop, not_full, elig0, elig1, pick1, head;

  always_comb begin
    ddr_address    = m0_address;
    ddr_byteenable = m0_byteenable;
    ddr_writedata  = m0_writedata;
    ddr_read       = 1'b0;
    ddr_write      = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state_q)
      GRANT0: begin
        ddr_read       = m0_read;
        ddr_write      = m0_write;
        m0_waitrequest = ddr_waitrequest;
      end
      GRANT1: begin
        ddr_address    = m1_address;
        ddr_byteenable = m1_byteenable;
        ddr_writedata  = m1_writedata;
        ddr_read       = m1_read;
        ddr_write      = m1_write;
        m1_waitrequest = ddr_waitrequest;
      end
      default: ;
    endcase
    // Reset is synchronous, so mask outputs before the first reset edge settles the state.
    if (reset) begin
      ddr_read       = 1'b0;
      ddr_write      = 1'b0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
    end
  end

  assign accept = (ddr_read | ddr_write) & ~ddr_waitrequest;
  assign push   = accept & ddr_read;
  assign pop    = ddr_readdatavalid & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  // Eligibility looks at the count after this cycle's push/pop, so a read is only granted with room for its tag.
  assign not_full = cnt_d < CW'(MAX_PENDING);
  assign elig0    = m0_write | (m0_read & not_full);
  assign elig1    = m1_write | (m1_read & not_full);
  assign rr_d     = accept ? (state_q == GRANT0) : rr_q;

`ifdef DDR2_ARB_FIXED_PRIORITY_EN
  assign pick1 = elig1;
`else
  assign pick1 = elig1 & (~elig0 | rr_d);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (elig0 | elig1) state_d = pick1 ? GRANT1 : GRANT0;
      GRANT0, GRANT1: begin
        if (accept)
          state_d = (elig0 | elig1) ? (pick1 ? GRANT1 : GRANT0) : IDLE;
        else if (!ddr_read && !ddr_write)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (ddr_readdatavalid && cnt_q == '0) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr_q] <= (state_q == GRANT1);
  end

  assign head             = tag_q[rd_ptr_q];
  assign m0_readdata      = ddr_readdata;
  assign m1_readdata      = ddr_readdata;
  assign m0_readdatavalid = pop & ~head & ~reset;
  assign m1_readdatavalid = pop & head & ~reset;
  assign err_orphan       = err_q;
endmodule
